// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: state encodings, memory geometry, reset PC.
// Also holds the Start legality rule shared by the loader.
package imem_loader_pkg;

  localparam int IM_DEPTH = 1024;
  localparam int IM_AW    = 10;
  localparam int CNT_W    = 11;
  localparam int SPAN_W   = CNT_W + 1;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    imld_idle = 2'd0,
    imld_load = 2'd1,
    imld_done = 2'd2
  } imld_state_t;

  // Extra bit keeps out-of-range Count from wrapping into a legal span.
  function automatic logic start_legal(
    input logic [IM_AW-1:0] base,
    input logic [CNT_W-1:0] count,
    input int               depth
  );
    logic [SPAN_W-1:0] span;
    span = {2'b00, base} + {1'b0, count};
    return (count != '0) && (span <= SPAN_W'(depth));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host-side bundle of the instruction memory loader:
// byte stream in, memory write port and status out.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic             Start;
  logic [IM_AW-1:0] Base;
  logic [CNT_W-1:0] Count;
  logic             Byte_Valid;
  logic [7:0]       Byte_Data;
  logic             Byte_Ready;
  logic             Im_WE;
  logic [IM_AW-1:0] Im_Addr;
  logic [31:0]      Im_WData;
  logic             Busy;
  logic             Hold_Cpu;
  logic             Done;
  logic             Err;
  logic [31:0]      Checksum;

  modport master (
    output Start, Base, Count, Byte_Valid, Byte_Data,
    input  Byte_Ready, Im_WE, Im_Addr, Im_WData,
    input  Busy, Hold_Cpu, Done, Err, Checksum
  );

  modport slave (
    input  Start, Base, Count, Byte_Valid, Byte_Data,
    output Byte_Ready, Im_WE, Im_Addr, Im_WData,
    output Busy, Hold_Cpu, Done, Err, Checksum
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs four accepted bytes big-endian into one word;
// Word_Valid pulses the cycle after the fourth byte.
module word_packer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Take,
  input  logic [7:0]  Byte_Data,
  input  logic        Clear,
  output logic [31:0] Word,
  output logic        Word_Valid
);

  logic [1:0]  cnt_q;
  logic [31:0] sr_q;
  logic        wv_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
      wv_q  <= 1'b0;
    end else if (Clear) begin
      cnt_q <= '0;
      sr_q  <= '0;
      wv_q  <= 1'b0;
    end else begin
      wv_q <= Take && (cnt_q == 2'd3);
      if (Take) begin
        sr_q  <= {sr_q[23:0], Byte_Data};
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  assign Word       = sr_q;
  assign Word_Valid = wv_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: byte stream to word writes at Base..,
// holds the CPU in reset while loading and keeps a running checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IM_DEPTH = imem_loader_pkg::IM_DEPTH
) (
  input logic          Clk,
  input logic          Reset,
  imem_loader_if.slave bus
);

  imld_state_t      state_q, state_d;
  logic [IM_AW-1:0] addr_q;
  logic [CNT_W-1:0] rem_q;
  logic [31:0]      csum_q;
  logic             err_q;

  logic [31:0] word;
  logic        wv;
  logic        take;
  logic        ready;
  logic        accept;
  logic        last;
  logic        in_idle;

  assign in_idle = (state_q == imld_idle);
  assign accept  = in_idle && bus.Start &&
                   start_legal(bus.Base, bus.Count, IM_DEPTH);
  assign last    = wv && (rem_q == CNT_W'(1));

  // A word being written this cycle no longer needs bytes.
  assign ready = (state_q == imld_load) &&
                 (rem_q > {{(CNT_W-1){1'b0}}, wv});
  assign take  = ready && bus.Byte_Valid;

  word_packer u_packer (
    .Clk        (Clk),
    .Reset      (Reset),
    .Take       (take),
    .Byte_Data  (bus.Byte_Data),
    .Clear      (accept),
    .Word       (word),
    .Word_Valid (wv)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      imld_idle: if (accept) state_d = imld_load;
      imld_load: if (last) state_d = imld_done;
      imld_done: state_d = imld_idle;
      default:   state_d = imld_idle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= imld_idle;
      addr_q  <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= in_idle && bus.Start && !accept;
      if (accept) begin
        addr_q <= bus.Base;
        rem_q  <= bus.Count;
        csum_q <= '0;
      end else if (wv) begin
        csum_q <= csum_q + word;
        rem_q  <= rem_q - CNT_W'(1);
        if (!last) addr_q <= addr_q + IM_AW'(1);
      end
    end
  end

  assign bus.Byte_Ready = ready;
  assign bus.Im_WE      = wv;
  assign bus.Im_Addr    = addr_q;
  assign bus.Im_WData   = word;
  assign bus.Busy       = !in_idle;
  assign bus.Hold_Cpu   = !in_idle;
  assign bus.Done       = (state_q == imld_done);
  assign bus.Err        = err_q;
  assign bus.Checksum   = csum_q;

endmodule
